// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC register, credit-limited memory requests,
// in-order response buffering toward decode, and redirect flush with stale-response drop.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pcplus4
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);
    localparam logic [CW-1:0] CONE    = CW'(1);
    localparam logic [PW-1:0] PONE    = PW'(1);

    logic [31:0]   pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] fifo_count;

    // Address queue: one entry per outstanding request, popped by each response.
    logic [31:0]   aq_mem [DEPTH];
    logic [PW-1:0] aq_wr;
    logic [PW-1:0] aq_rd;

    logic [31:0]   fi_instr [DEPTH];
    logic [31:0]   fi_pc    [DEPTH];
    logic [PW-1:0] fi_wr;
    logic [PW-1:0] fi_rd;

    logic [CW:0]   credit_sum;
    logic          req_fire;
    logic          rsp_fire;
    logic          rsp_drop;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_empty;
    logic [31:0]   aq_head;
    logic [31:0]   head_pc;

    always_comb begin
        credit_sum     = {1'b0, outstanding} + {1'b0, fifo_count};
        imem_req_valid = rst_n && !redirect_valid && (credit_sum < DEPTH_W);
        imem_req_addr  = pc;
        req_fire       = imem_req_valid && imem_req_ready;

        // Responses with nothing outstanding belong to a pre-reset request.
        rsp_fire   = imem_rsp_valid && (outstanding != '0);
        rsp_drop   = rsp_fire && (redirect_valid || (drop_cnt != '0));
        fifo_push  = rsp_fire && !rsp_drop;
        aq_head    = aq_mem[aq_rd];

        fifo_empty = (fifo_count == '0);
        id_valid   = !fifo_empty && !redirect_valid;
        fifo_pop   = id_valid && id_ready;

        head_pc    = fi_pc[fi_rd];
        id_instr   = fifo_empty ? '0 : fi_instr[fi_rd];
        id_pc      = fifo_empty ? '0 : head_pc;
        id_pcplus4 = fifo_empty ? '0 : head_pc + 32'd4;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            aq_wr       <= '0;
            aq_rd       <= '0;
            fi_wr       <= '0;
            fi_rd       <= '0;
            fifo_count  <= '0;
        end else begin
            if (redirect_valid) begin
                pc <= redirect_pc & 32'hFFFF_FFFC;
            end else if (req_fire) begin
                pc <= pc + 32'd4;
            end

            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_fire);

            // Every request still in flight at a redirect is stale, minus the one answered now.
            if (redirect_valid) begin
                drop_cnt <= outstanding - CW'(rsp_fire);
            end else if (rsp_fire && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CONE;
            end

            if (req_fire) begin
                aq_wr <= aq_wr + PONE;
            end
            if (rsp_fire) begin
                aq_rd <= aq_rd + PONE;
            end

            if (redirect_valid) begin
                fi_wr      <= '0;
                fi_rd      <= '0;
                fifo_count <= '0;
            end else begin
                if (fifo_push) begin
                    fi_wr <= fi_wr + PONE;
                end
                if (fifo_pop) begin
                    fi_rd <= fi_rd + PONE;
                end
                fifo_count <= fifo_count + CW'(fifo_push) - CW'(fifo_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) begin
            aq_mem[aq_wr] <= pc;
        end
        if (fifo_push) begin
            fi_instr[fi_wr] <= imem_rsp_data;
            fi_pc[fi_wr]    <= aq_head;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table for fill/stall/resume, hand sequences
// for redirect, reset mid-stream and PC wrap.
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h0040_0000;
    localparam logic [31:0] WPC = 32'hFFFF_FFFC;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        req_valid, req_ready, rsp_valid, redir_valid, id_valid, id_ready;
    logic [31:0] req_addr, rsp_data, redir_pc, id_instr, id_pc, id_pcplus4;

    logic        man, m_valid, a_valid;
    logic [31:0] m_data, a_data;

    fetch_unit #(.RESET_PC(RPC), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
        .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
        .redirect_valid(redir_valid), .redirect_pc(redir_pc),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_instr(id_instr), .id_pc(id_pc), .id_pcplus4(id_pcplus4)
    );

    // Latency-1 memory: answers every accepted request in the next cycle with ~addr.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid <= 1'b0;
            a_data  <= '0;
        end else begin
            a_valid <= req_valid && req_ready;
            a_data  <= ~req_addr;
        end
    end
    assign rsp_valid = man ? m_valid : a_valid;
    assign rsp_data  = man ? m_data  : a_data;

    logic        w_req_valid, w_rsp_valid, w_id_valid;
    logic [31:0] w_req_addr, w_rsp_data, w_id_instr, w_id_pc, w_id_pcplus4;
    logic        one = 1'b1;
    logic        zero = 1'b0;
    logic [31:0] zero32 = '0;

    fetch_unit #(.RESET_PC(WPC)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(w_req_valid), .imem_req_ready(one), .imem_req_addr(w_req_addr),
        .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
        .redirect_valid(zero), .redirect_pc(zero32),
        .id_valid(w_id_valid), .id_ready(one),
        .id_instr(w_id_instr), .id_pc(w_id_pc), .id_pcplus4(w_id_pcplus4)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_rsp_valid <= 1'b0;
            w_rsp_data  <= '0;
        end else begin
            w_rsp_valid <= w_req_valid;
            w_rsp_data  <= ~w_req_addr;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            total++;
            if (32'(dut.outstanding) + 32'(dut.fifo_count) > 32'd4) begin
                bad++;
                $display("FAIL inv_credit: outstanding=%0d fifo_count=%0d limit=4",
                         dut.outstanding, dut.fifo_count);
            end
            total++;
            if (dut.drop_cnt > dut.outstanding) begin
                bad++;
                $display("FAIL inv_drop: drop_cnt=%0d exceeds outstanding=%0d",
                         dut.drop_cnt, dut.outstanding);
            end
        end
    end

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] addr;
        logic        idv;
        logic [31:0] pc;
    } vec_t;

    function automatic vec_t mk(logic rdy, logic rv, int an, logic idv, int pn);
        vec_t v;
        v.rdy  = rdy;
        v.rv   = rv;
        v.addr = RPC + 32'(4 * an);
        v.idv  = idv;
        v.pc   = RPC + 32'(4 * pn);
        return v;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        man = 1'b1; m_valid = 1'b0; m_data = '0;
        req_ready = 1'b0; id_ready = 1'b0; redir_valid = 1'b0; redir_pc = '0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    vec_t tbl [15];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0]  = mk(1, 1, 0, 0, 0);
        tbl[1]  = mk(1, 1, 1, 0, 0);
        tbl[2]  = mk(1, 1, 2, 1, 0);
        tbl[3]  = mk(1, 1, 3, 1, 1);
        tbl[4]  = mk(0, 1, 4, 1, 2);
        tbl[5]  = mk(0, 1, 5, 1, 2);
        tbl[6]  = mk(0, 0, 6, 1, 2);
        tbl[7]  = mk(0, 0, 6, 1, 2);
        tbl[8]  = mk(0, 0, 6, 1, 2);
        tbl[9]  = mk(0, 0, 6, 1, 2);
        tbl[10] = mk(1, 0, 6, 1, 2);
        tbl[11] = mk(1, 1, 6, 1, 3);
        tbl[12] = mk(1, 1, 7, 1, 4);
        tbl[13] = mk(1, 1, 8, 1, 5);
        tbl[14] = mk(1, 1, 9, 1, 6);

        man = 1'b0; m_valid = 1'b0; m_data = '0;
        req_ready = 1'b1; id_ready = 1'b1; redir_valid = 1'b0; redir_pc = '0;

        @(posedge clk); #1;
        chk("rst_req_valid", req_valid, 0);
        chk("rst_id_valid", id_valid, 0);
        chk("rst_id_instr", id_instr, 0);
        chk("rst_id_pc", id_pc, 0);
        chk("rst_id_pcplus4", id_pcplus4, 0);
        chk("rst_req_addr", req_addr, RPC);
        chk("rst_w_req_valid", w_req_valid, 0);
        rst_n = 1'b1;

        for (int k = 0; k < 15; k++) begin
            if (k > 0) next_cycle();
            id_ready = tbl[k].rdy;
            @(negedge clk);
            chk($sformatf("tbl%0d_req_valid", k), req_valid, tbl[k].rv);
            chk($sformatf("tbl%0d_req_addr", k), req_addr, tbl[k].addr);
            chk($sformatf("tbl%0d_id_valid", k), id_valid, tbl[k].idv);
            if (tbl[k].idv) begin
                chk($sformatf("tbl%0d_id_pc", k), id_pc, tbl[k].pc);
                chk($sformatf("tbl%0d_id_instr", k), id_instr, ~tbl[k].pc);
                chk($sformatf("tbl%0d_id_pcplus4", k), id_pcplus4, tbl[k].pc + 32'd4);
            end
            if (k == 8) chk("stall_fifo_count", 32'(dut.fifo_count), 4);
            if (k == 0) chk("wrap_addr0", w_req_addr, WPC);
            if (k == 1) begin
                chk("wrap_addr1", w_req_addr, 32'h0000_0000);
                chk("wrap_req_valid1", w_req_valid, 1);
            end
            if (k == 2) begin
                chk("wrap_id_valid", w_id_valid, 1);
                chk("wrap_id_pc", w_id_pc, WPC);
                chk("wrap_id_pcplus4", w_id_pcplus4, 32'h0000_0000);
                chk("wrap_id_instr", w_id_instr, 32'h0000_0003);
            end
        end

        // Redirect with two requests outstanding.
        do_reset();
        redir_valid = 1'b1; redir_pc = 32'h0000_0100;
        @(negedge clk);
        chk("rd1_setup_no_req", req_valid, 0);
        next_cycle();
        redir_valid = 1'b0; req_ready = 1'b1;
        @(negedge clk);
        chk("rd1_addr_100", req_addr, 32'h0000_0100);
        next_cycle();
        @(negedge clk);
        chk("rd1_addr_104", req_addr, 32'h0000_0104);
        next_cycle();
        req_ready = 1'b0; redir_valid = 1'b1; redir_pc = 32'h0000_0203;
        @(negedge clk);
        chk("rd1_redir_req_valid", req_valid, 0);
        chk("rd1_redir_id_valid", id_valid, 0);
        next_cycle();
        redir_valid = 1'b0; req_ready = 1'b1;
        @(negedge clk);
        chk("rd1_target_addr", req_addr, 32'h0000_0200);
        chk("rd1_target_req_valid", req_valid, 1);
        chk("rd1_drop_2", 32'(dut.drop_cnt), 2);
        next_cycle();
        req_ready = 1'b0; m_valid = 1'b1; m_data = 32'hDEAD_0100;
        @(negedge clk);
        chk("rd1_idv_during_drop", id_valid, 0);
        next_cycle();
        m_data = 32'hDEAD_0104;
        @(negedge clk);
        chk("rd1_drop_1", 32'(dut.drop_cnt), 1);
        next_cycle();
        m_data = 32'h1357_9BDF;
        @(negedge clk);
        chk("rd1_drop_0", 32'(dut.drop_cnt), 0);
        chk("rd1_stale_not_delivered", id_valid, 0);
        next_cycle();
        m_valid = 1'b0;
        @(negedge clk);
        chk("rd1_first_id_valid", id_valid, 1);
        chk("rd1_first_id_pc", id_pc, 32'h0000_0200);
        chk("rd1_first_id_instr", id_instr, 32'h1357_9BDF);
        chk("rd1_first_id_pcplus4", id_pcplus4, 32'h0000_0204);

        // Redirect coinciding with a response, one more request still outstanding.
        do_reset();
        redir_valid = 1'b1; redir_pc = 32'h0000_0100;
        next_cycle();
        redir_valid = 1'b0; req_ready = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rd2_addr_108", req_addr, 32'h0000_0108);
        next_cycle();
        req_ready = 1'b0; m_valid = 1'b1; m_data = 32'h1111_0100;
        next_cycle();
        m_data = 32'h2222_0104; redir_valid = 1'b1; redir_pc = 32'h0000_0300;
        @(negedge clk);
        chk("rd2_redir_id_valid", id_valid, 0);
        chk("rd2_redir_req_valid", req_valid, 0);
        next_cycle();
        m_valid = 1'b0; redir_valid = 1'b0; req_ready = 1'b1;
        @(negedge clk);
        chk("rd2_flushed", id_valid, 0);
        chk("rd2_drop_1", 32'(dut.drop_cnt), 1);
        chk("rd2_target_addr", req_addr, 32'h0000_0300);
        next_cycle();
        req_ready = 1'b0; m_valid = 1'b1; m_data = 32'h3333_0108;
        @(negedge clk);
        chk("rd2_idv_during_drop", id_valid, 0);
        next_cycle();
        m_data = 32'h4444_0300;
        next_cycle();
        m_valid = 1'b0;
        @(negedge clk);
        chk("rd2_id_valid", id_valid, 1);
        chk("rd2_id_pc", id_pc, 32'h0000_0300);
        chk("rd2_id_instr", id_instr, 32'h4444_0300);

        // Asynchronous reset mid-stream with 2 outstanding and 2 buffered.
        do_reset();
        req_ready = 1'b1;
        next_cycle();
        next_cycle();
        next_cycle();
        next_cycle();
        req_ready = 1'b0; m_valid = 1'b1; m_data = 32'hAAAA_0000;
        next_cycle();
        m_data = 32'hAAAA_0004;
        next_cycle();
        m_valid = 1'b0;
        @(negedge clk);
        chk("rs_fifo_count", 32'(dut.fifo_count), 2);
        chk("rs_outstanding", 32'(dut.outstanding), 2);
        chk("rs_full_req_valid", req_valid, 0);
        chk("rs_pre_id_pc", id_pc, RPC);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_async_id_valid", id_valid, 0);
        chk("rs_async_id_instr", id_instr, 0);
        chk("rs_async_id_pc", id_pc, 0);
        chk("rs_async_id_pcplus4", id_pcplus4, 0);
        chk("rs_async_req_valid", req_valid, 0);
        chk("rs_async_req_addr", req_addr, RPC);
        next_cycle();
        rst_n = 1'b1;
        m_valid = 1'b1; m_data = 32'hBADB_AD00;
        next_cycle();
        m_valid = 1'b0;
        @(negedge clk);
        chk("rs_stray_ignored", id_valid, 0);
        chk("rs_stray_fifo", 32'(dut.fifo_count), 0);
        chk("rs_restart_addr", req_addr, RPC);
        chk("rs_restart_req_valid", req_valid, 1);
        next_cycle();
        req_ready = 1'b1;
        next_cycle();
        req_ready = 1'b0; m_valid = 1'b1; m_data = 32'h5555_AAAA;
        next_cycle();
        m_valid = 1'b0;
        @(negedge clk);
        chk("rs_post_id_valid", id_valid, 1);
        chk("rs_post_id_pc", id_pc, RPC);
        chk("rs_post_id_instr", id_instr, 32'h5555_AAAA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
